// File: rtl/spike_aer_arbiter_if.sv
// -----------------------------------------------------------------------------
// spike_aer_arbiter_if
// Address-event (AER) stream carrying one spike event per valid/ready transfer.
//
//   valid : event present on addr/ts (source -> sink)
//   ready : sink accepts the event on a clk edge where valid & ready
//   addr  : index of the neuron that spiked
//   ts    : timestep during which the spike was captured
//
// Modports: master = event source (arbiter), slave = event sink (router).
// -----------------------------------------------------------------------------
interface spike_aer_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int TS_W   = 16
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [TS_W-1:0]   ts;

  modport master (output valid, output addr, output ts, input ready);
  modport slave  (input valid, input addr, input ts, output ready);
endinterface

// File: rtl/spike_aer_arbiter.sv
// -----------------------------------------------------------------------------
// spike_aer_arbiter
// Collects one-cycle spike pulses from N_NEURONS neurons and serialises them
// onto a single AER stream with fair round-robin arbitration. Each neuron has
// a one-deep pending slot holding the timestep at capture; a spike arriving
// while its slot is still occupied is dropped and counted.
//
// Ports:
//   clk         : system clock, all state on rising edge
//   rst_n       : asynchronous active-low reset
//   tick        : timestep strobe, advances the ts counter
//   spike_in    : per-neuron spike pulses, bit i = neuron i
//   clear_drops : synchronous clear of drop_count (wins over increments)
//   drop_count  : saturating count of spikes lost to overflow
//   busy        : any event pending or in the output register
//   aer         : AER event stream (master side)
//
// The ts counter is assumed narrower than 32 bits, as is DROP_W.
// -----------------------------------------------------------------------------
module spike_aer_arbiter #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int TS_W      = 16,
  parameter int DROP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 clear_drops,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 busy,
  spike_aer_arbiter_if.master  aer
);

  localparam logic [31:0] DROP_MAX = 32'((64'd1 << DROP_W) - 64'd1);

  // Registered state
  logic [N_NEURONS-1:0] pending;
  logic [TS_W-1:0]      cap_ts [N_NEURONS];
  logic [ADDR_W-1:0]    rr_ptr;
  logic [TS_W-1:0]      ts;

  // Combinational decisions for the current edge
  logic                 slot_free;
  logic                 grant_valid;
  logic [ADDR_W-1:0]    grant_idx;
  logic                 load;
  logic [N_NEURONS-1:0] load_mask;
  logic [N_NEURONS-1:0] capture_mask;
  logic [N_NEURONS-1:0] drop_mask;
  logic [31:0]          n_drops;
  logic [31:0]          drop_sum;
  logic [DROP_W-1:0]    drop_next;
  logic [ADDR_W-1:0]    rr_next;

  // The output register can take a new event when empty or being drained.
  assign slot_free = !aer.valid || aer.ready;

  // Round-robin search: lowest set pending bit at or above rr_ptr wins; if
  // there is none, fall back to the lowest set bit below rr_ptr (the wrap).
  // The second loop runs last so an upper-half hit overrides a wrapped one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i] && (i < int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant_idx   = ADDR_W'(i);
      end
    end
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i] && (i >= int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant_idx   = ADDR_W'(i);
      end
    end
  end

  assign load = slot_free && grant_valid;

  always_comb begin
    load_mask = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      load_mask[i] = load && (grant_idx == ADDR_W'(i));
    end
  end

  // A neuron whose slot is emptied on this edge may capture again at once,
  // so a spike coinciding with its own load is a second event, not a drop.
  assign capture_mask = spike_in & (~pending | load_mask);
  assign drop_mask    = spike_in & pending & ~load_mask;

  assign n_drops  = 32'($countones(drop_mask));
  assign drop_sum = 32'(drop_count) + n_drops;

  always_comb begin
    if (clear_drops) begin
      drop_next = '0;
    end else if (drop_sum > DROP_MAX) begin
      drop_next = DROP_W'(DROP_MAX);
    end else begin
      drop_next = DROP_W'(drop_sum);
    end
  end

  // With a single neuron the pointer is pinned to 0 by this wrap.
  assign rr_next = (grant_idx == ADDR_W'(N_NEURONS - 1)) ? '0
                                                         : grant_idx + ADDR_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      rr_ptr     <= '0;
      ts         <= '0;
      drop_count <= '0;
      aer.valid  <= 1'b0;
      aer.addr   <= '0;
      aer.ts     <= '0;
    end else begin
      pending    <= (pending & ~load_mask) | capture_mask;
      drop_count <= drop_next;
      if (tick) begin
        ts <= ts + TS_W'(1);
      end
      if (slot_free) begin
        aer.valid <= grant_valid;
        if (grant_valid) begin
          aer.addr <= grant_idx;
          aer.ts   <= cap_ts[grant_idx];
          rr_ptr   <= rr_next;
        end
      end
    end
  end

  // NOTE: the capture array is plain flops rather than RAM, so it takes the
  // asynchronous reset too and no stale timestamp survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cap_ts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (capture_mask[i]) begin
          cap_ts[i] <= ts;
        end
      end
    end
  end

  assign busy = (|pending) || aer.valid;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spike_aer_arbiter
// Self-checking bench for spike_aer_arbiter (N_NEURONS=8, TS_W=16, DROP_W=8).
// A behavioural model tracks pending events, timestamps and drops; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_spike_aer_arbiter;

  localparam int N      = 8;
  localparam int ADDR_W = 3;
  localparam int TS_W   = 16;
  localparam int DROP_W = 8;

  logic              clk;
  logic              rst_n;
  logic              tick;
  logic [N-1:0]      spike_in;
  logic              clear_drops;
  logic [DROP_W-1:0] drop_count;
  logic              busy;

  spike_aer_arbiter_if #(.ADDR_W(ADDR_W), .TS_W(TS_W)) aer ();

  spike_aer_arbiter #(
    .N_NEURONS(N),
    .ADDR_W   (ADDR_W),
    .TS_W     (TS_W),
    .DROP_W   (DROP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .spike_in   (spike_in),
    .clear_drops(clear_drops),
    .drop_count (drop_count),
    .busy       (busy),
    .aer        (aer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one pending flag + timestamp per neuron, a round-robin
  // start point, the timestep, the drop total and the presented event.
  // ---------------------------------------------------------------------------
  bit          m_pend [N];
  int unsigned m_cap  [N];
  int          m_rr;
  int unsigned m_ts;
  int unsigned m_drop;
  bit          m_valid;
  int          m_addr;
  int unsigned m_ets;

  always @(posedge clk or negedge rst_n) begin : model
    bit          free;
    int          g;
    int unsigned nd;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= 1'b0;
        m_cap[i]  <= 0;
      end
      m_rr <= 0; m_ts <= 0; m_drop <= 0;
      m_valid <= 1'b0; m_addr <= 0; m_ets <= 0;
    end else begin
      free = !m_valid || (aer.ready === 1'b1);
      g = -1;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
      end
      nd = 0;
      for (int i = 0; i < N; i++) begin
        if (spike_in[i]) begin
          if (!m_pend[i] || g == i) begin
            m_pend[i] <= 1'b1;
            m_cap[i]  <= m_ts;
          end else begin
            nd++;
          end
        end else if (g == i) begin
          m_pend[i] <= 1'b0;
        end
      end
      if (free) begin
        if (g >= 0) begin
          m_valid <= 1'b1;
          m_addr  <= g;
          m_ets   <= m_cap[g];
          m_rr    <= (g + 1) % N;
        end else begin
          m_valid <= 1'b0;
        end
      end
      if (tick) m_ts <= (m_ts + 1) % (1 << TS_W);
      if (clear_drops)                        m_drop <= 0;
      else if (m_drop + nd > (1 << DROP_W) - 1) m_drop <= (1 << DROP_W) - 1;
      else                                    m_drop <= m_drop + nd;
    end
  end

  function automatic bit model_busy();
    bit b;
    b = m_valid;
    for (int i = 0; i < N; i++) b |= m_pend[i];
    return b;
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_valid", 32'(aer.valid), 32'(m_valid));
      check("cmp_addr",  32'(aer.addr),  32'(m_addr));
      check("cmp_ts",    32'(aer.ts),    m_ets);
      check("cmp_drops", 32'(drop_count), m_drop);
      check("cmp_busy",  32'(busy),      32'(model_busy()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at the next one)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    spike_in = '0; tick = 1'b0; clear_drops = 1'b0; aer.ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "time budget expired");
  end

  initial begin : stim
    rst_n = 1'b0; spike_in = '0; tick = 1'b0; clear_drops = 1'b0; aer.ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    check("rst_valid", 32'(aer.valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_drops", 32'(drop_count), 0);

    // Single spike: ts=5, neuron 3, two-edge latency, one-cycle event
    aer.ready = 1'b1;
    tick = 1'b1;
    repeat (5) cycle();
    tick = 1'b0;
    check("model_ts_after_ticks", m_ts, 5);
    spike_in = 8'h08;
    cycle();
    spike_in = '0;
    check("single_latency_valid", 32'(aer.valid), 0);
    check("single_latency_busy",  32'(busy), 1);
    cycle();
    check("single_valid", 32'(aer.valid), 1);
    check("single_addr",  32'(aer.addr), 3);
    check("single_ts",    32'(aer.ts), 5);
    cycle();
    check("single_done_valid", 32'(aer.valid), 0);
    check("single_done_busy",  32'(busy), 0);

    // Burst: all neurons at once, drained 0..7 back-to-back
    do_reset();
    aer.ready = 1'b1;
    spike_in = 8'hFF;
    cycle();
    spike_in = '0;
    cycle();
    for (int k = 0; k < N; k++) begin
      check("burst_valid", 32'(aer.valid), 1);
      check("burst_addr",  32'(aer.addr), 32'(k));
      check("burst_ts",    32'(aer.ts), 0);
      cycle();
    end
    check("burst_end_valid", 32'(aer.valid), 0);
    check("model_rr_after_burst", 32'(m_rr), 0);

    // Fairness: after neuron 5 is granted, 6 beats 2
    do_reset();
    aer.ready = 1'b1;
    spike_in = 8'h20;
    cycle();
    spike_in = 8'h44;
    cycle();
    spike_in = '0;
    check("fair_first", 32'(aer.addr), 5);
    cycle();
    check("fair_second", 32'(aer.addr), 6);
    cycle();
    check("fair_third", 32'(aer.addr), 2);

    // Backpressure: neuron 7 stalls in the output register; neuron 1 spikes
    // at cycles 2 and 6 (second one dropped), neuron 2 at cycle 3. ts = cycle.
    do_reset();
    tick = 1'b1;
    for (int t = 0; t < 10; t++) begin
      case (t)
        0:       spike_in = 8'h80;
        2, 6:    spike_in = 8'h02;
        3:       spike_in = 8'h04;
        default: spike_in = '0;
      endcase
      cycle();
      if (t >= 1) begin
        check("stall_valid", 32'(aer.valid), 1);
        check("stall_addr",  32'(aer.addr), 7);
        check("stall_ts",    32'(aer.ts), 0);
      end
    end
    spike_in = '0;
    check("stall_drops", 32'(drop_count), 1);
    check("model_stall_drops", m_drop, 1);
    aer.ready = 1'b1;
    cycle();
    check("stall_n1_addr", 32'(aer.addr), 1);
    check("stall_n1_ts",   32'(aer.ts), 2);
    cycle();
    check("stall_n2_addr", 32'(aer.addr), 2);
    check("stall_n2_ts",   32'(aer.ts), 3);
    cycle();
    check("stall_end_valid", 32'(aer.valid), 0);
    tick = 1'b0;

    // Re-spike on the edge that loads neuron 4: two events, no drop
    do_reset();
    aer.ready = 1'b1;
    tick = 1'b1;
    spike_in = 8'h10;
    cycle();
    tick = 1'b0;
    cycle();
    spike_in = '0;
    check("respike_first_addr", 32'(aer.addr), 4);
    check("respike_first_ts",   32'(aer.ts), 0);
    cycle();
    check("respike_second_valid", 32'(aer.valid), 1);
    check("respike_second_addr",  32'(aer.addr), 4);
    check("respike_second_ts",    32'(aer.ts), 1);
    check("respike_drops",        32'(drop_count), 0);
    cycle();
    check("respike_end_valid", 32'(aer.valid), 0);

    // Saturation, clear priority, asynchronous reset mid-stream
    do_reset();
    spike_in = 8'hFF;
    repeat (50) cycle();
    check("sat_drops", 32'(drop_count), 255);
    clear_drops = 1'b1;
    cycle();
    clear_drops = 1'b0;
    check("clear_drops", 32'(drop_count), 0);
    repeat (2) cycle();
    check("post_clear_drops", 32'(drop_count), 16);
    spike_in = '0;
    aer.ready = 1'b1;
    repeat (2) cycle();
    check("midstream_valid", 32'(aer.valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(aer.valid), 0);
    check("async_rst_busy",  32'(busy), 0);
    check("async_rst_drops", 32'(drop_count), 0);
    check("async_rst_addr",  32'(aer.addr), 0);
    check("async_rst_ts",    32'(aer.ts), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      spike_in    = ($urandom_range(0, 99) < 40) ? N'($urandom & $urandom) : '0;
      tick        = ($urandom_range(0, 3) == 0);
      aer.ready   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 25));
      clear_drops = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cycle();
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
